// File: rtl/lcd_bus_responder.sv
// HD44780-style character-LCD responder: decodes bus strobes, keeps a 128-byte DDRAM image,
// address counter and display-control state, and answers busy-flag and data reads.
module lcd_bus_responder #(
    parameter int unsigned BUSY_CYCLES = 40,
    parameter int unsigned CLR_CYCLES  = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    output logic       db_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       cmd_valid,
    output logic       cmd_rs,
    output logic [7:0] cmd_code,
    output logic       proto_err,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data
);

    typedef enum logic [1:0] {StIdle, StBusy, StClear} state_e;

    localparam logic [15:0] BusyLoad = 16'(BUSY_CYCLES - 1);
    localparam logic [15:0] ClrLast  = 16'(CLR_CYCLES - 1);

    state_e      st_q, st_d;
    logic [15:0] cnt_q, cnt_d;
    logic        e_q, rs_q, rw_q;
    logic [7:0]  db_q;
    logic        busy_q, busy_d;
    logic [6:0]  ac_q, ac_d;
    logic        disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
    logic        inc_q, inc_d, shift_q, shift_d, cg_mode_q, cg_mode_d;
    logic        cmd_valid_q, cmd_valid_d, cmd_rs_q, cmd_rs_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic        err_q, err_d;
    logic [7:0]  db_out_q, db_out_d;
    logic        db_oe_q, db_oe_d;
    logic [7:0]  rd_data_q;
    logic [7:0]  mem_q [128];
    logic        mem_we;
    logic [6:0]  mem_wa;
    logic [7:0]  mem_wd;
    logic        strobe_end, wr_acc, rd_src_rs;
    logic [7:0]  rd_value;

    // Two-line address map: 0x00-0x27 and 0x40-0x67; anything else steps mod 128.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        if (inc) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h00) return 7'h67;
        if (a == 7'h40) return 7'h27;
        return a - 7'd1;
    endfunction

    always_comb begin
        strobe_end  = e_q & ~e;
        wr_acc      = strobe_end & ~rw_q & ~busy_q;
        st_d        = st_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        ac_d        = ac_q;
        disp_d      = disp_q;
        cursor_d    = cursor_q;
        blink_d     = blink_q;
        inc_d       = inc_q;
        shift_d     = shift_q;
        cg_mode_d   = cg_mode_q;
        cmd_valid_d = 1'b0;
        cmd_rs_d    = cmd_rs_q;
        cmd_code_d  = cmd_code_q;
        err_d       = err_q;
        db_out_d    = db_out_q;
        mem_we      = 1'b0;
        mem_wa      = ac_q;
        mem_wd      = db_q;

        // While E is high the live rs selects the read source; at strobe end the latched one.
        rd_src_rs = e ? rs : rs_q;
        if (rd_src_rs) rd_value = busy_q ? 8'h00 : mem_q[ac_q];
        else           rd_value = {busy_q, ac_q};
        db_oe_d = (e & rw) | (strobe_end & rw_q);
        if (db_oe_d) db_out_d = rd_value;

        unique case (st_q)
            StClear: begin
                if (cnt_q < 16'd128) begin
                    mem_we = 1'b1;
                    mem_wa = cnt_q[6:0];
                    mem_wd = 8'h20;
                end
                if (cnt_q == ClrLast) begin
                    st_d   = StIdle;
                    busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StBusy: begin
                if (cnt_q == 16'd0) begin
                    st_d   = StIdle;
                    busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: ;
        endcase

        if (wr_acc) begin
            cmd_valid_d = 1'b1;
            cmd_rs_d    = rs_q;
            cmd_code_d  = db_q;
            st_d        = StBusy;
            busy_d      = 1'b1;
            cnt_d       = BusyLoad;
            if (rs_q) begin
                if (!cg_mode_q) begin
                    mem_we = 1'b1;
                    ac_d   = ac_step(ac_q, inc_q);
                end
            end else begin
                priority casez (db_q)
                    8'b1???????: begin
                        ac_d      = db_q[6:0];
                        cg_mode_d = 1'b0;
                    end
                    8'b01??????: cg_mode_d = 1'b1;
                    8'b001?????: if (!db_q[4]) err_d = 1'b1;
                    8'b0001????: if (!db_q[3]) ac_d = ac_step(ac_q, db_q[2]);
                    8'b00001???: begin
                        disp_d   = db_q[2];
                        cursor_d = db_q[1];
                        blink_d  = db_q[0];
                    end
                    8'b000001??: begin
                        inc_d   = db_q[1];
                        shift_d = db_q[0];
                    end
                    8'b0000001?: begin
                        ac_d      = 7'h00;
                        cg_mode_d = 1'b0;
                        cnt_d     = ClrLast;
                    end
                    8'b00000001: begin
                        ac_d      = 7'h00;
                        inc_d     = 1'b1;
                        cg_mode_d = 1'b0;
                        st_d      = StClear;
                        cnt_d     = 16'd0;
                    end
                    default: ;
                endcase
            end
        end else if (strobe_end & ~rw_q) begin
            err_d = 1'b1;
        end else if (strobe_end & rw_q & rs_q) begin
            if (busy_q) err_d = 1'b1;
            else        ac_d  = ac_step(ac_q, inc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= StClear;
            cnt_q       <= 16'd0;
            e_q         <= 1'b0;
            rs_q        <= 1'b0;
            rw_q        <= 1'b0;
            db_q        <= 8'h00;
            busy_q      <= 1'b1;
            ac_q        <= 7'h00;
            disp_q      <= 1'b0;
            cursor_q    <= 1'b0;
            blink_q     <= 1'b0;
            inc_q       <= 1'b1;
            shift_q     <= 1'b0;
            cg_mode_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_rs_q    <= 1'b0;
            cmd_code_q  <= 8'h00;
            err_q       <= 1'b0;
            db_out_q    <= 8'h00;
            db_oe_q     <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            e_q         <= e;
            rs_q        <= rs;
            rw_q        <= rw;
            db_q        <= db_in;
            busy_q      <= busy_d;
            ac_q        <= ac_d;
            disp_q      <= disp_d;
            cursor_q    <= cursor_d;
            blink_q     <= blink_d;
            inc_q       <= inc_d;
            shift_q     <= shift_d;
            cg_mode_q   <= cg_mode_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_rs_q    <= cmd_rs_d;
            cmd_code_q  <= cmd_code_d;
            err_q       <= err_d;
            db_out_q    <= db_out_d;
            db_oe_q     <= db_oe_d;
        end
    end

    // DDRAM has no reset; the CLEAR state initialises it after every reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_wa] <= mem_wd;
        rd_data_q <= mem_q[rd_addr];
    end

    assign db_out    = db_out_q;
    assign db_oe     = db_oe_q;
    assign busy      = busy_q;
    assign ac        = ac_q;
    assign disp_on   = disp_q;
    assign cursor_on = cursor_q;
    assign blink_on  = blink_q;
    assign entry_inc = inc_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_rs    = cmd_rs_q;
    assign cmd_code  = cmd_code_q;
    assign proto_err = err_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder: a vector table of bus writes plus hand-written
// sequences for reset/clear timing, busy-window drops, reads and the peek port.
module tb_lcd_bus_responder;

    localparam int unsigned BusyCycles = 40;
    localparam int unsigned ClrCycles  = 1600;

    logic       clk = 1'b0;
    logic       rst, e, rs, rw;
    logic [7:0] db_in, db_out, cmd_code, rd_data;
    logic       db_oe, busy, disp_on, cursor_on, blink_on, entry_inc;
    logic       cmd_valid, cmd_rs, proto_err;
    logic [6:0] ac, rd_addr;

    int checks = 0;
    int errors = 0;

    lcd_bus_responder #(
        .BUSY_CYCLES(BusyCycles),
        .CLR_CYCLES (ClrCycles)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .e        (e),
        .rs       (rs),
        .rw       (rw),
        .db_in    (db_in),
        .db_out   (db_out),
        .db_oe    (db_oe),
        .busy     (busy),
        .ac       (ac),
        .disp_on  (disp_on),
        .cursor_on(cursor_on),
        .blink_on (blink_on),
        .entry_inc(entry_inc),
        .cmd_valid(cmd_valid),
        .cmd_rs   (cmd_rs),
        .cmd_code (cmd_code),
        .proto_err(proto_err),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rs;
        logic [7:0] db;
        logic [6:0] ac;
        logic [3:0] ctl;  // {disp, cursor, blink, entry_inc}
    } vec_t;

    vec_t vecs [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic r, input logic [7:0] d);
        rs = r; rw = 1'b0; db_in = d; e = 1'b1;
        @(negedge clk);
        @(negedge clk);
        e = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic r, output logic [7:0] d, output logic oe);
        rs = r; rw = 1'b1; e = 1'b1;
        @(negedge clk);
        @(negedge clk);
        d  = db_out;
        oe = db_oe;
        e  = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < int'(ClrCycles) + 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic peek(input logic [6:0] a, input logic [7:0] exp, input string name);
        rd_addr = a;
        @(negedge clk);
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int         n;
        logic [7:0] d;
        logic       oe;

        vecs[0]  = '{1'b0, 8'h0F, 7'h00, 4'b1111};
        vecs[1]  = '{1'b0, 8'h06, 7'h00, 4'b1111};
        vecs[2]  = '{1'b0, 8'h80, 7'h00, 4'b1111};
        vecs[3]  = '{1'b0, 8'hA7, 7'h27, 4'b1111};
        vecs[4]  = '{1'b1, 8'h41, 7'h40, 4'b1111};
        vecs[5]  = '{1'b1, 8'h42, 7'h41, 4'b1111};
        vecs[6]  = '{1'b0, 8'h04, 7'h41, 4'b1110};
        vecs[7]  = '{1'b0, 8'h80, 7'h00, 4'b1110};
        vecs[8]  = '{1'b1, 8'h33, 7'h67, 4'b1110};
        vecs[9]  = '{1'b0, 8'h14, 7'h00, 4'b1110};
        vecs[10] = '{1'b0, 8'h10, 7'h67, 4'b1110};
        vecs[11] = '{1'b0, 8'h1C, 7'h67, 4'b1110};
        vecs[12] = '{1'b0, 8'h06, 7'h67, 4'b1111};
        vecs[13] = '{1'b0, 8'hFF, 7'h7F, 4'b1111};
        vecs[14] = '{1'b0, 8'h14, 7'h00, 4'b1111};
        vecs[15] = '{1'b0, 8'h0C, 7'h00, 4'b1001};
        vecs[16] = '{1'b0, 8'h00, 7'h00, 4'b1001};
        vecs[17] = '{1'b0, 8'h40, 7'h00, 4'b1001};
        vecs[18] = '{1'b1, 8'h55, 7'h00, 4'b1001};
        vecs[19] = '{1'b0, 8'h80, 7'h00, 4'b1001};
        vecs[20] = '{1'b0, 8'h38, 7'h00, 4'b1001};
        vecs[21] = '{1'b0, 8'hC0, 7'h40, 4'b1001};
        vecs[22] = '{1'b0, 8'h10, 7'h27, 4'b1001};
        vecs[23] = '{1'b0, 8'hA7, 7'h27, 4'b1001};

        // Hold a status read on the bus through reset release.
        rst = 1'b1; e = 1'b1; rs = 1'b0; rw = 1'b1; db_in = 8'h00; rd_addr = 7'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ac", 32'(ac), 32'd0);
        chk("rst_ctl", 32'({disp_on, cursor_on, blink_on, entry_inc}), 32'b0001);
        chk("rst_err_valid_oe", 32'({proto_err, cmd_valid, db_oe}), 32'd0);
        chk("rst_db_out", 32'(db_out), 32'd0);
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < int'(ClrCycles) + 200) begin
            n++;
            if (n == 10) begin
                chk("bf_oe_during_clear", 32'(db_oe), 32'd1);
                chk("bf_during_clear", 32'(db_out), 32'h80);
            end
            @(negedge clk);
        end
        chk("clear_busy_cycles", 32'(n), 32'(ClrCycles));
        @(negedge clk);
        chk("bf_after_clear", 32'(db_out), 32'h00);
        e = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("oe_released", 32'(db_oe), 32'd0);
        peek(7'h00, 8'h20, "peek_clr_00");
        peek(7'h27, 8'h20, "peek_clr_27");
        peek(7'h7F, 8'h20, "peek_clr_7f");

        for (int i = 0; i < 24; i++) begin
            bus_write(vecs[i].rs, vecs[i].db);
            chk($sformatf("v%0d_cmd_valid", i), 32'(cmd_valid), 32'd1);
            chk($sformatf("v%0d_cmd", i), 32'({cmd_rs, cmd_code}), 32'({vecs[i].rs, vecs[i].db}));
            count_busy(n);
            chk($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(BusyCycles));
            chk($sformatf("v%0d_ac", i), 32'(ac), 32'(vecs[i].ac));
            chk($sformatf("v%0d_ctl", i), 32'({disp_on, cursor_on, blink_on, entry_inc}),
                32'(vecs[i].ctl));
            chk($sformatf("v%0d_err", i), 32'(proto_err), 32'd0);
        end
        peek(7'h27, 8'h41, "peek_27");
        peek(7'h40, 8'h42, "peek_40");
        peek(7'h00, 8'h33, "peek_00_cg_discard");
        peek(7'h67, 8'h20, "peek_67");

        // Write dropped inside the busy window; status and data reads still answered.
        bus_write(1'b0, 8'h06);
        repeat (4) @(negedge clk);
        bus_write(1'b0, 8'h90);
        chk("drop_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("drop_err", 32'(proto_err), 32'd1);
        chk("drop_ac", 32'(ac), 32'h27);
        bus_read(1'b0, d, oe);
        chk("busy_bf_read", 32'(d), 32'hA7);
        chk("busy_bf_oe", 32'(oe), 32'd1);
        chk("busy_oe_drop", 32'(db_oe), 32'd0);
        bus_read(1'b1, d, oe);
        chk("busy_data_read", 32'(d), 32'h00);
        chk("busy_data_ac", 32'(ac), 32'h27);
        count_busy(n);
        chk("busy_done", 32'(busy), 32'd0);
        bus_read(1'b1, d, oe);
        chk("data_read_27", 32'(d), 32'h41);
        chk("data_read_ac", 32'(ac), 32'h40);
        bus_read(1'b1, d, oe);
        chk("data_read_40", 32'(d), 32'h42);
        chk("data_read_ac2", 32'(ac), 32'h41);

        bus_write(1'b0, 8'h02);
        chk("home_ac", 32'(ac), 32'd0);
        count_busy(n);
        chk("home_busy_cycles", 32'(n), 32'(ClrCycles));
        peek(7'h00, 8'h33, "home_keeps_ddram");

        // Peek of an address written on the same edge returns the old byte.
        bus_write(1'b0, 8'h85);
        count_busy(n);
        rd_addr = 7'h05;
        @(negedge clk);
        chk("peek_05_before", 32'(rd_data), 32'h20);
        bus_write(1'b1, 8'h77);
        chk("peek_05_same_edge", 32'(rd_data), 32'h20);
        @(negedge clk);
        chk("peek_05_after", 32'(rd_data), 32'h77);
        count_busy(n);

        // Reset mid-clear must restart the full clear.
        bus_write(1'b0, 8'h90);
        count_busy(n);
        bus_write(1'b0, 8'h01);
        chk("clr_instr_busy", 32'(busy), 32'd1);
        chk("clr_instr_ac", 32'(ac), 32'd0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_ac", 32'(ac), 32'd0);
        chk("midrst_err", 32'(proto_err), 32'd0);
        chk("midrst_ctl", 32'({disp_on, cursor_on, blink_on, entry_inc}), 32'b0001);
        rst = 1'b0;
        count_busy(n);
        chk("midrst_clear_cycles", 32'(n), 32'(ClrCycles));
        peek(7'h27, 8'h20, "midrst_peek_27");
        peek(7'h40, 8'h20, "midrst_peek_40");
        peek(7'h05, 8'h20, "midrst_peek_05");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_bus_responder.md
Name: lcd_bus_responder

Overview:
- Synthesizable responder for the HD44780-style character-LCD bus (E, RS, RW, DB[7:0]) that the data path drives.
- Decodes instructions, holds a DDRAM image, address counter and display-control state, and returns the busy flag and data on reads.
- Serves as the far end of the LCD interface in the top-level benches. It can also act as an on-chip mirror, readable through a peek port, for the dot-matrix or debug paths.

Parameters:
BUSY_CYCLES, 40, clk cycles busy=1 after any accepted write other than clear/home
CLR_CYCLES, 1600, clk cycles busy=1 after clear display, return home and reset release; must be >=128

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
e  input  1  LCD enable strobe, same clock domain
rs  input  1  register select: 0 = instruction/status, 1 = data
rw  input  1  1 = read, 0 = write
db_in  input  8  bus data from initiator
db_out  output  8  read data to initiator
db_oe  output  1  responder drives bus
busy  output  1  busy flag
ac  output  7  address counter
disp_on  output  1  D bit
cursor_on  output  1  C bit
blink_on  output  1  B bit
entry_inc  output  1  I/D bit
cmd_valid  output  1  one-cycle pulse per accepted write
cmd_rs  output  1  rs of accepted write
cmd_code  output  8  db of accepted write
proto_err  output  1  sticky: write attempted while busy, or DL=0
rd_addr  input  7  DDRAM peek address
rd_data  output  8  DDRAM peek data, 1-cycle latency

Behaviour:
- Reset is synchronous.
  - Outputs: db_out=0, db_oe=0, ac=0, disp_on=0, cursor_on=0, blink_on=0, entry_inc=1, cmd_valid=0, proto_err=0.
  - busy=1, and the FSM enters CLEAR.
  - Reset asserted mid-operation aborts any clear or busy count.
- Bus sampling:
  - e, rs, rw and db_in are registered every cycle into e_q, rs_q, rw_q, db_q.
  - A strobe end is e_q=1 and e=0. The transaction uses rs_q, rw_q and db_q, i.e. values from the last cycle E was high.
- FSM states: IDLE, BUSY, CLEAR.
  - CLEAR: writes 0x20 to one DDRAM address per cycle, 0..127. It then holds busy until the counter reaches CLR_CYCLES, then goes to IDLE. Return home uses BUSY with CLR_CYCLES and does not touch DDRAM.
  - BUSY: counts down from the loaded value. At 0 it goes to IDLE with busy=0 on the following cycle.
- Write accepted (rw_q=0 and busy=0 at strobe end):
  - cmd_valid pulses on the next cycle.
  - Instruction decode is by the highest set bit of db_q:
    - 0x01 clear: ac=0, entry_inc=1, enter CLEAR.
    - 0x02 return home: ac=0, enter BUSY with CLR_CYCLES.
    - 0x04 entry mode: entry_inc=db[1]; the S bit is stored but has no effect.
    - 0x08 display control: D, C, B.
    - 0x10 shift: when S/C=0, ac steps ±1 per R/L. Display shift is ignored.
    - 0x20 function set: DL=0 sets proto_err.
    - 0x40 CGRAM address: sets cg_mode=1.
    - 0x80 DDRAM address: ac=db[6:0], cg_mode=0.
    - 0x00 is a no-op, but cmd_valid still pulses.
  - Data write (rs=1): when cg_mode=0, DDRAM[ac]=db, then ac advances per entry_inc. When cg_mode=1, data is discarded and ac is unchanged.
  - All accepted writes except clear and home then enter BUSY for BUSY_CYCLES.
- Write while busy=1: dropped; proto_err is set; no other state changes.
- Read (rw=1):
  - db_oe=1 from the cycle after e rises until the cycle after the strobe end.
  - rs=0: db_out={busy, ac}. Reads are allowed while busy and do not touch state.
  - rs=1 and busy=0: db_out=DDRAM[ac], and ac advances at the strobe end.
  - rs=1 and busy=1: db_out=0x00, and proto_err is set.
- ac wrap (2-line map):
  - Increment: 0x27 goes to 0x40; 0x67 goes to 0x00.
  - Decrement: 0x00 goes to 0x67; 0x40 goes to 0x27.
  - Setting an out-of-map address via 0x80 is taken as written. The next step from an out-of-map value wraps mod 128.
- Peek port: rd_data=DDRAM[rd_addr] registered. A write to the same address in the same cycle returns old data.

Test Plan:
- Release reset, poll BF with rs=0, rw=1 → busy=1 for exactly CLR_CYCLES cycles. Peek 0x00, 0x27, 0x7F → all 0x20. db_out[7]=0 after.
- Write instr 0x0F, 0x06, 0x80 → disp_on=cursor_on=blink_on=1, entry_inc=1, ac=0. cmd_valid pulses 3 times with cmd_code 0x0F, 0x06, 0x80.
- Write 0xA7, then data 'A' (0x41) and 'B' → peek 0x27=0x41, 0x40=0x42, ac=0x41.
- Write entry mode 0x04, address 0x80, data 0x33 → DDRAM[0]=0x33, ac=0x67.
- Issue a write 5 cycles after the previous accepted write → dropped, proto_err=1, ac unchanged. A BF read in the same window returns db_out[7]=1.
- Assert rst during CLEAR → busy restarts, ac=0, proto_err=0, and CLEAR re-runs fully.
